// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared types for the handshaked sequential ALU: opcode and
//               state enumerations, the flag bundle, and an opcode legality
//               helper. Legality of opcode 110 depends on ALU_SEQ_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_XOR  = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_MUL  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } alu_state_e;

    typedef struct packed {
        logic zf;
        logic cf;
        logic vf;
        logic err;
    } alu_flags_t;

    localparam alu_flags_t c_flags_reset = '{zf: 1'b0, cf: 1'b0, vf: 1'b0, err: 1'b0};

    // True when the opcode is one this build implements.
    function automatic logic op_is_legal(input alu_op_e op);
`ifdef ALU_SEQ_MUL_EN
        return (op != OP_RSVD);
`else
        return (op != OP_RSVD) && (op != OP_MUL);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative unsigned shift-add multiplier, one partial product
//               per cycle. start loads the operands; done is raised during
//               the cycle in which the final step is being applied, and
//               product already includes that final step, so the consumer
//               can capture it on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign done       = r_busy && (r_cnt == c_last);
    assign product    = w_acc_next;

    // Operand load on start, then one shift-add step per cycle while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_acc    <= '0;
            r_mplier <= b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Handshaked sequential ALU. Accepts one operation on a
//               valid/ready input port, holds the registered result and
//               flags on a valid/ready output port until consumed.
//               Build option: define ALU_SEQ_MUL_EN to include the iterative
//               multiplier (opcode 110 through the BUSY state); otherwise
//               opcode 110 is reported as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zf,
    output logic             cf,
    output logic             vf,
    output logic             err
);

    localparam int               c_msb   = WIDTH - 1;
    localparam logic [WIDTH-1:0] c_width = WIDTH'(WIDTH);

    alu_state_e       r_state;
    alu_state_e       w_state_next;
    logic [WIDTH-1:0] r_out;
    alu_flags_t       r_flags;

    alu_op_e          w_op;
    logic [WIDTH-1:0] w_res;
    alu_flags_t       w_flags;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_shift_oor;
    logic             w_load_alu;

`ifdef ALU_SEQ_MUL_EN
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;
    logic               w_load_mul;
    alu_flags_t         w_mul_flags;
`endif

    assign w_op      = alu_op_e'(op);
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign zf        = r_flags.zf;
    assign cf        = r_flags.cf;
    assign vf        = r_flags.vf;
    assign err       = r_flags.err;

    // Single-cycle result and flags for every opcode except MUL.
    always_comb begin
        w_res       = '0;
        w_flags     = c_flags_reset;
        w_sum       = {1'b0, r2} + {1'b0, r1};
        w_diff      = {1'b0, r2} - {1'b0, r1};
        w_shift_oor = (r1 >= c_width);
        if (!op_is_legal(w_op)) begin
            w_flags.err = 1'b1;
        end else begin
            case (w_op)
                OP_AND: w_res = r2 & r1;
                OP_XOR: w_res = r2 ^ r1;
                OP_SHL: w_res = w_shift_oor ? '0 : (r2 << r1);
                OP_SHR: w_res = w_shift_oor ? '0 : (r2 >> r1);
                OP_ADD: begin
                    w_res      = w_sum[WIDTH-1:0];
                    w_flags.cf = w_sum[WIDTH];
                    w_flags.vf = (r1[c_msb] == r2[c_msb]) && (w_sum[c_msb] != r2[c_msb]);
                end
                OP_SUB: begin
                    w_res      = w_diff[WIDTH-1:0];
                    w_flags.cf = w_diff[WIDTH];
                    w_flags.vf = (r1[c_msb] != r2[c_msb]) && (w_diff[c_msb] != r2[c_msb]);
                end
                default: w_res = '0;
            endcase
        end
        w_flags.zf = (w_res == '0);
    end

`ifdef ALU_SEQ_MUL_EN
    // Low half is the result; any bit set in the high half signals carry.
    always_comb begin
        w_mul_flags    = c_flags_reset;
        w_mul_flags.zf = (w_mul_product[WIDTH-1:0] == '0);
        w_mul_flags.cf = |w_mul_product[2*WIDTH-1:WIDTH];
    end

    alu_mul_iter #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (r1),
        .b       (r2),
        .done    (w_mul_done),
        .product (w_mul_product)
    );
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and load strobes; inputs are only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_load_alu   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        w_mul_start  = 1'b0;
        w_load_mul   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (w_op == OP_MUL) begin
                        w_mul_start  = 1'b1;
                        w_state_next = S_BUSY;
                    end else begin
                        w_load_alu   = 1'b1;
                        w_state_next = S_DONE;
                    end
`else
                    w_load_alu   = 1'b1;
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_BUSY: begin
                if (w_mul_done) begin
                    w_load_mul   = 1'b1;
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result and flags change only when DONE is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out   <= '0;
            r_flags <= c_flags_reset;
        end else if (w_load_alu) begin
            r_out   <= w_res;
            r_flags <= w_flags;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (w_load_mul) begin
            r_out   <= w_mul_product[WIDTH-1:0];
            r_flags <= w_mul_flags;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (WIDTH = 8). Directed cases
//               with literal expectations plus randomized traffic compared
//               every cycle against an arithmetic reference model.
//               Honors ALU_SEQ_MUL_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [2:0] op        = 3'd0;
    logic [7:0] r1        = 8'd0;
    logic [7:0] r2        = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out;
    logic       zf, cf, vf, err;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;
    bit rand_rdy    = 1'b0;

    // Reference model state
    bit m_ready = 1'b1;
    bit m_valid = 1'b0;
    int m_wait  = 0;
    int m_out   = 0;
    bit m_zf = 1'b0, m_cf = 1'b0, m_vf = 1'b0, m_err = 1'b0;
    int p_out;
    bit p_zf, p_cf, p_vf, p_err;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .r1        (r1),
        .r2        (r2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zf        (zf),
        .cf        (cf),
        .vf        (vf),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Result and flags from the arithmetic definition of each opcode.
    function automatic void predict(input int o, input int a, input int b,
                                    output int res, output bit fz, output bit fc,
                                    output bit fv, output bit fe);
        int s;
        res = 0; fc = 1'b0; fv = 1'b0; fe = 1'b0;
        case (o)
            0: res = a & b;
            1: res = a ^ b;
            2: res = (a >= 8) ? 0 : ((b << a) & 255);
            3: res = (a >= 8) ? 0 : (b >> a);
            4: begin
                s   = b + a;
                res = s & 255;
                fc  = (s > 255);
                s   = sgn(b) + sgn(a);
                fv  = (s > 127) || (s < -128);
            end
            5: begin
                res = (b - a) & 255;
                fc  = (a > b);
                s   = sgn(b) - sgn(a);
                fv  = (s > 127) || (s < -128);
            end
            6: begin
                if (MUL_EN) begin
                    s   = b * a;
                    res = s & 255;
                    fc  = ((s >> 8) != 0);
                end else begin
                    fe = 1'b1;
                end
            end
            default: fe = 1'b1;
        endcase
        fz = (res == 0);
    endfunction

    // Transaction-level model: one op in flight, held result, async reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ready = 1'b1; m_valid = 1'b0; m_wait = 0;
            m_out = 0; m_zf = 1'b0; m_cf = 1'b0; m_vf = 1'b0; m_err = 1'b0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_out = p_out; m_zf = p_zf; m_cf = p_cf; m_vf = p_vf; m_err = p_err;
            end
        end else if (in_valid) begin
            predict(int'(op), int'(r1), int'(r2), p_out, p_zf, p_cf, p_vf, p_err);
            m_ready = 1'b0;
            if (MUL_EN && op == 3'b110) begin
                m_wait = 8;
            end else begin
                m_valid = 1'b1;
                m_out = p_out; m_zf = p_zf; m_cf = p_cf; m_vf = p_vf; m_err = p_err;
            end
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", int'(in_ready), int'(m_ready));
            check("out_valid", int'(out_valid), int'(m_valid));
            check("out", int'(out), m_out);
            check("zf", int'(zf), int'(m_zf));
            check("cf", int'(cf), int'(m_cf));
            check("vf", int'(vf), int'(m_vf));
            check("err", int'(err), int'(m_err));
        end
    end

    // Randomized consumer backpressure.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        op = o; r1 = a; r2 = b; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("issue_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_consume", int'(in_ready), 1);
    endtask

    task automatic expect_res(input string name, input int lat, input int n,
                              input int o, input int z, input int c, input int v, input int e);
        check({name, "_lat"}, n + 1, lat);
        check({name, "_out"}, int'(out), o);
        check({name, "_zf"}, int'(zf), z);
        check({name, "_cf"}, int'(cf), c);
        check({name, "_vf"}, int'(vf), v);
        check({name, "_err"}, int'(err), e);
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out", int'(out), 0);
        check("rst_flags", int'({zf, cf, vf, err}), 0);

        issue(3'b100, 8'hFF, 8'h01); wait_valid(n);
        expect_res("add_carry", 1, n, 'h00, 1, 1, 0, 0); consume();
        issue(3'b100, 8'h40, 8'h40); wait_valid(n);
        expect_res("add_ovf", 1, n, 'h80, 0, 0, 1, 0); consume();
        issue(3'b101, 8'h05, 8'h03); wait_valid(n);
        expect_res("sub_borrow", 1, n, 'hFE, 0, 1, 0, 0); consume();
        issue(3'b010, 8'd9, 8'hFF); wait_valid(n);
        expect_res("shl_oor", 1, n, 'h00, 1, 0, 0, 0); consume();
        issue(3'b011, 8'd4, 8'hF0); wait_valid(n);
        expect_res("shr", 1, n, 'h0F, 0, 0, 0, 0); consume();

        // Backpressure: result must hold while a new request is waiting.
        issue(3'b001, 8'hAA, 8'h0F); wait_valid(n);
        op = 3'b100; r1 = 8'h11; r2 = 8'h22; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out", int'(out), 'hA5);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        consume();

        issue(3'b111, 8'h12, 8'h34); wait_valid(n);
        expect_res("rsvd", 1, n, 'h00, 1, 0, 0, 1); consume();
        issue(3'b110, 8'h10, 8'h11); wait_valid(n);
        if (MUL_EN) expect_res("mul", 9, n, 'h10, 0, 1, 0, 0);
        else        expect_res("mul_off", 1, n, 'h00, 1, 0, 0, 1);
        consume();

        // Reset in the middle of an operation.
        issue(3'b110, 8'h10, 8'h11);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        #2;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_out", int'(out), 0);
        check("abort_flags", int'({zf, cf, vf, err}), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Randomized traffic, boundary-biased shift amounts.
        rand_rdy = 1'b1;
        for (int t = 0; t < 400; t++) begin
            logic [2:0] ro;
            logic [7:0] ra, rb;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ro, ra, rb);
        end
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
